// File: rtl/tpg_pkg.sv
// Shared encodings and colour constants for the VGA test-pattern sequencer.
package tpg_pkg;

    typedef enum logic [2:0] {
        MODE_BARS    = 3'd0,
        MODE_H_GRAD  = 3'd1,
        MODE_CHECKER = 3'd2,
        MODE_GRID    = 3'd3,
        MODE_SOLID   = 3'd4
    } tpg_mode_e;

    localparam int          MODE_NUM = 5;
    localparam logic [9:0]  FULL     = 10'h3FF;
    localparam logic [29:0] RGB_BLACK = 30'd0;
    localparam logic [29:0] RGB_WHITE = {FULL, FULL, FULL};

    // Bar colours, left to right, as {R,G,B}.
    localparam logic [29:0] BAR_RGB [8] = '{
        {FULL,  FULL,  FULL },
        {FULL,  FULL,  10'd0},
        {10'd0, FULL,  FULL },
        {10'd0, FULL,  10'd0},
        {FULL,  10'd0, FULL },
        {FULL,  10'd0, 10'd0},
        {10'd0, 10'd0, FULL },
        {10'd0, 10'd0, 10'd0}
    };

    function automatic tpg_mode_e mode_sanitize(input logic [2:0] m);
        return (m < 3'(MODE_NUM)) ? tpg_mode_e'(m) : MODE_BARS;
    endfunction

    function automatic tpg_mode_e mode_next(input tpg_mode_e m);
        return (m == MODE_SOLID) ? MODE_BARS : tpg_mode_e'(m + 3'd1);
    endfunction

endpackage

// File: rtl/tpg_sequencer_if.sv
// Pixel/sync bus between color_bar and the sequencer, plus pattern controls.
interface tpg_sequencer_if;
    logic [10:0] iCoord_X;
    logic [10:0] iCoord_Y;
    logic        iVGA_V_SYNC;
    logic        iAuto;
    logic [2:0]  iMode;
    logic        iNext;
    logic [29:0] iSolid_RGB;
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic [2:0]  oMode;
    logic [7:0]  oFrame_cnt;

    modport master (
        output iCoord_X, iCoord_Y, iVGA_V_SYNC, iAuto, iMode, iNext, iSolid_RGB,
        input  oRed, oGreen, oBlue, oMode, oFrame_cnt
    );

    modport slave (
        input  iCoord_X, iCoord_Y, iVGA_V_SYNC, iAuto, iMode, iNext, iSolid_RGB,
        output oRed, oGreen, oBlue, oMode, oFrame_cnt
    );
endinterface

// File: rtl/tpg_pixel_gen.sv
// Stateless pattern generator: maps (mode, X, Y) to a 30-bit {R,G,B} colour.
module tpg_pixel_gen
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CHK_LOG2 = 5
) (
    input  tpg_mode_e   mode_i,
    input  logic [10:0] x_i,
    input  logic [10:0] y_i,
    input  logic [29:0] solid_i,
    output logic [29:0] rgb_o
);
    localparam logic [10:0] BAR_W  = 11'(H_ACTIVE / 8);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

    logic       active;
    logic [2:0] bar_idx;
    logic       grid_on;

    assign active  = (x_i < 11'(H_ACTIVE)) && (y_i < 11'(V_ACTIVE));
    assign bar_idx = 3'(x_i / BAR_W);
    assign grid_on = (x_i[CHK_LOG2-1:0] == '0) || (y_i[CHK_LOG2-1:0] == '0) ||
                     (x_i == X_LAST) || (y_i == Y_LAST);

    always_comb begin
        rgb_o = RGB_BLACK;
        if (active) begin
            case (mode_i)
                MODE_BARS:    rgb_o = BAR_RGB[bar_idx];
                MODE_H_GRAD:  rgb_o = {x_i[9:0], x_i[9:0], x_i[9:0]};
                MODE_CHECKER: rgb_o = (x_i[CHK_LOG2] ^ y_i[CHK_LOG2]) ? RGB_WHITE : RGB_BLACK;
                MODE_GRID:    rgb_o = grid_on ? RGB_WHITE : RGB_BLACK;
                MODE_SOLID:   rgb_o = solid_i;
                default:      rgb_o = BAR_RGB[bar_idx];
            endcase
        end
    end
endmodule

// File: rtl/tpg_sequencer.sv
// Frame-start detector, pattern-mode FSM and registered pixel output for color_bar.
module tpg_sequencer
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int FRAMES_PER_MODE = 60,
    parameter int CHK_LOG2        = 5
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    tpg_sequencer_if.slave  bus
);
    localparam int            FW       = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [FW-1:0] FIM_LAST = FW'(FRAMES_PER_MODE - 1);

    logic          vs_q;
    logic          fs_q;
    logic          next_pend_q;
    tpg_mode_e     mode_q;
    logic [FW-1:0] fim_q;
    logic [7:0]    fcnt_q;
    logic [29:0]   rgb_q;
    logic [29:0]   rgb_d;
    logic          advance;

    tpg_pixel_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pix (
        .mode_i  (mode_q),
        .x_i     (bus.iCoord_X),
        .y_i     (bus.iCoord_Y),
        .solid_i (bus.iSolid_RGB),
        .rgb_o   (rgb_d)
    );

    // A pending or coincident iNext and the auto rollover share one advance.
    assign advance = next_pend_q || bus.iNext || (bus.iAuto && (fim_q == FIM_LAST));

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            vs_q        <= 1'b1;
            fs_q        <= 1'b0;
            next_pend_q <= 1'b0;
            mode_q      <= MODE_BARS;
            fim_q       <= '0;
            fcnt_q      <= '0;
            rgb_q       <= '0;
        end else begin
            vs_q  <= bus.iVGA_V_SYNC;
            fs_q  <= vs_q && !bus.iVGA_V_SYNC;
            rgb_q <= rgb_d;
            if (fs_q) begin
                next_pend_q <= 1'b0;
                fcnt_q      <= fcnt_q + 8'd1;
                if (advance) begin
                    mode_q <= mode_next(mode_q);
                    fim_q  <= '0;
                end else if (!bus.iAuto) begin
                    mode_q <= mode_sanitize(bus.iMode);
                    fim_q  <= '0;
                end else begin
                    fim_q  <= fim_q + 1'b1;
                end
            end else if (bus.iNext) begin
                next_pend_q <= 1'b1;
            end
        end
    end

    assign bus.oRed       = rgb_q[29:20];
    assign bus.oGreen     = rgb_q[19:10];
    assign bus.oBlue      = rgb_q[9:0];
    assign bus.oMode      = mode_q;
    assign bus.oFrame_cnt = fcnt_q;
endmodule

// File: tb/tb_tpg_sequencer.sv
// Randomised bench for tpg_sequencer against a frame-level behavioural model.
module tb_tpg_sequencer;
    localparam int F = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tpg_sequencer_if vif();

    tpg_sequencer #(
        .H_ACTIVE        (640),
        .V_ACTIVE        (480),
        .FRAMES_PER_MODE (F),
        .CHK_LOG2        (5)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (vif)
    );

    int n_chk = 0;
    int n_pass = 0;

    int m_mode = 0;
    int m_fim  = 0;
    int m_fcnt = 0;
    bit m_pend = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [29:0] exp_rgb(input int mode, input int x, input int y,
                                            input logic [29:0] solid);
        int          code [8] = '{7, 6, 3, 2, 5, 4, 1, 0};
        int          c;
        logic [9:0]  v;
        logic [29:0] white;
        white = {10'h3FF, 10'h3FF, 10'h3FF};
        if (x >= 640 || y >= 480) return 30'd0;
        case (mode)
            0: begin
                c = code[x / 80];
                return {((c & 4) != 0) ? 10'h3FF : 10'h000,
                        ((c & 2) != 0) ? 10'h3FF : 10'h000,
                        ((c & 1) != 0) ? 10'h3FF : 10'h000};
            end
            1: begin
                v = 10'(x % 1024);
                return {v, v, v};
            end
            2: return (((x / 32) + (y / 32)) % 2 == 1) ? white : 30'd0;
            3: return (x % 32 == 0 || y % 32 == 0 || x == 639 || y == 479) ? white : 30'd0;
            4: return solid;
            default: return 30'd0;
        endcase
    endfunction

    function automatic logic [31:0] dut_rgb();
        return {2'b00, vif.oRed, vif.oGreen, vif.oBlue};
    endfunction

    task automatic pix(input int x, input int y);
        @(negedge clk);
        vif.iCoord_X = 11'(x);
        vif.iCoord_Y = 11'(y);
        @(negedge clk);
        check($sformatf("rgb m%0d (%0d,%0d)", m_mode, x, y), dut_rgb(),
              {2'b00, exp_rgb(m_mode, x, y, vif.iSolid_RGB)});
    endtask

    task automatic pulse_next();
        @(negedge clk);
        vif.iNext = 1'b1;
        @(negedge clk);
        vif.iNext = 1'b0;
        m_pend = 1'b1;
    endtask

    // One vsync pulse; optionally raise iNext exactly in the frame-start cycle.
    task automatic frame(input bit next_at_fs);
        @(negedge clk);
        vif.iVGA_V_SYNC = 1'b0;
        @(negedge clk);
        if (next_at_fs) vif.iNext = 1'b1;
        @(negedge clk);
        vif.iNext = 1'b0;
        vif.iVGA_V_SYNC = 1'b1;
        if (m_pend || next_at_fs || (vif.iAuto && m_fim == F - 1)) begin
            m_mode = (m_mode + 1) % 5;
            m_fim  = 0;
        end else if (!vif.iAuto) begin
            m_mode = (vif.iMode > 4) ? 0 : int'(vif.iMode);
            m_fim  = 0;
        end else begin
            m_fim++;
        end
        m_pend = 1'b0;
        m_fcnt = (m_fcnt + 1) % 256;
        check("mode after FS", 32'(vif.oMode), 32'(m_mode));
        check("frame_cnt", 32'(vif.oFrame_cnt), 32'(m_fcnt));
    endtask

    task automatic model_reset();
        m_mode = 0; m_fim = 0; m_fcnt = 0; m_pend = 1'b0;
    endtask

    initial begin
        vif.iCoord_X    = 11'd80;
        vif.iCoord_Y    = 11'd10;
        vif.iVGA_V_SYNC = 1'b1;
        vif.iAuto       = 1'b1;
        vif.iMode       = 3'd0;
        vif.iNext       = 1'b0;
        vif.iSolid_RGB  = 30'd0;

        repeat (3) @(negedge clk);
        check("rgb in reset", dut_rgb(), 32'd0);
        check("mode in reset", 32'(vif.oMode), 32'd0);
        check("fcnt in reset", 32'(vif.oFrame_cnt), 32'd0);
        rst_n = 1'b1;

        pix(0, 100); pix(40, 100); pix(79, 100); pix(80, 100); pix(560, 100);
        check("mode after release", 32'(vif.oMode), 32'd0);

        // Auto rotation, two frames per mode.
        for (int i = 0; i < 10; i++) begin
            frame(1'b0);
            pix($urandom_range(0, 639), $urandom_range(0, 479));
        end

        // Multiple iNext pulses in one manual frame give one advance.
        vif.iAuto = 1'b0;
        vif.iMode = 3'd0;
        pulse_next(); pulse_next(); pulse_next();
        frame(1'b0);
        frame(1'b0);

        // iNext coinciding with the auto rollover in mode 2.
        vif.iMode = 3'd2;
        frame(1'b0);
        vif.iAuto = 1'b1;
        frame(1'b0);
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);

        // Manual modes and pattern corners.
        vif.iAuto = 1'b0;
        vif.iMode = 3'd6;
        frame(1'b0);
        pix(100, 100);
        vif.iMode = 3'd2;
        frame(1'b0);
        pix(32, 0); pix(32, 32); pix(31, 31);
        vif.iMode = 3'd4;
        vif.iSolid_RGB = {10'h155, 10'h2AA, 10'h0F0};
        frame(1'b0);
        pix(100, 100); pix(640, 10); pix(10, 480);
        vif.iMode = 3'd1;
        frame(1'b0);
        pix(0, 0); pix(639, 200); pix(513, 7);
        vif.iMode = 3'd3;
        frame(1'b0);
        pix(0, 5); pix(639, 7); pix(5, 479); pix(33, 33); pix(64, 1);

        // One-cycle reset mid-frame in mode 3.
        pix(10, 10);
        @(negedge clk);
        vif.iCoord_X = 11'd80;
        vif.iCoord_Y = 11'd10;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("mode after reset", 32'(vif.oMode), 32'd0);
        check("fcnt after reset", 32'(vif.oFrame_cnt), 32'd0);
        @(negedge clk);
        check("rgb after reset", dut_rgb(), {2'b00, exp_rgb(0, 80, 10, vif.iSolid_RGB)});
        repeat (20) @(negedge clk);
        check("no spurious FS", 32'(vif.oFrame_cnt), 32'd0);
        check("mode held", 32'(vif.oMode), 32'd0);

        // Randomised frames.
        for (int i = 0; i < 60; i++) begin
            vif.iAuto      = 1'($urandom_range(0, 1));
            vif.iMode      = 3'($urandom_range(0, 7));
            vif.iSolid_RGB = 30'($urandom);
            for (int k = 0; k < 4; k++) pix($urandom_range(0, 700), $urandom_range(0, 520));
            if ($urandom_range(0, 3) == 0) pulse_next();
            if ($urandom_range(0, 5) == 0) pulse_next();
            frame($urandom_range(0, 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tpg_sequencer.md
# tpg_sequencer

Test-pattern sequencer for the VGA output path. It sits on the host side of `color_bar`: it takes the pixel coordinates and vertical sync back from `color_bar` and returns the 10-bit R/G/B that `color_bar` displays. Pattern changes happen only at frame boundaries, either by automatic rotation every N frames or by manual selection. It is the board-bring-up source used while the OV5640 capture path is not yet feeding the display.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `FRAMES_PER_MODE`, 60: frames per pattern in auto mode; must be ≥1.
- `CHK_LOG2`, 5: checker square and grid pitch = 2^CHK_LOG2 pixels.
- `iCLK`  in  1  pixel clock, same clock as `color_bar` (25 MHz).
- `iRST_N`  in  1  synchronous, active-low reset.
- `iCoord_X`  in  11  current pixel X from `color_bar` `oCoord_X`.
- `iCoord_Y`  in  11  current pixel Y from `color_bar` `oCoord_Y`.
- `iVGA_V_SYNC`  in  1  `color_bar` `oVGA_V_SYNC`, active-low.
- `iAuto`  in  1  1 = rotate modes automatically; 0 = manual.
- `iMode`  in  3  manual mode request, sampled at frame start when `iAuto`=0.
- `iNext`  in  1  single-cycle pulse requesting advance to the next mode (either auto setting).
- `iSolid_RGB`  in  30  {R,G,B} colour used by the SOLID mode.
- `oRed`, `oGreen`, `oBlue`  out  10 each  pixel colour; drives `color_bar` `iRed`/`iGreen`/`iBlue`.
- `oMode`  out  3  mode currently being displayed.
- `oFrame_cnt`  out  8  free-running frame counter; wraps 255→0.

## Operation
**Modes**
- BARS=0: 8 vertical bars, each `H_ACTIVE`/8 wide. Left to right: white, yellow, cyan, green, magenta, red, blue, black, using full-scale 10'h3FF / 0.
- H_GRAD=1: R=G=B=`iCoord_X[9:0]`.
- CHECKER=2: white when `iCoord_X[CHK_LOG2]` ^ `iCoord_Y[CHK_LOG2]` = 1, else black.
- GRID=3: white when `X[CHK_LOG2-1:0]`=0, or `Y[CHK_LOG2-1:0]`=0, or X=`H_ACTIVE`-1, or Y=`V_ACTIVE`-1; otherwise black.
- SOLID=4: `iSolid_RGB`.
- Codes 5–7 are invalid and are mapped to BARS wherever they appear.

**Frame start**
- Frame start (FS) is one cycle wide, asserted on the cycle that detects a 1→0 edge of the registered `iVGA_V_SYNC`.
- `frame_in_mode` counter range is 0..`FRAMES_PER_MODE`-1.

**Mode FSM**, single state register `mode`, updated only on FS. Priority at FS:
1. `iNext` pending or `iNext` high in the FS cycle: `mode` = (`mode`+1) mod 5, `frame_in_mode`=0.
2. Else if `iAuto`=1 and `frame_in_mode`=`FRAMES_PER_MODE`-1: `mode` = (`mode`+1) mod 5, `frame_in_mode`=0.
3. Else if `iAuto`=0: `mode` = `iMode` (5–7 → BARS), `frame_in_mode`=0.
4. Else: `frame_in_mode`+1.

**`iNext` handling**
- An `iNext` pulse between frame starts sets a `next_pend` flag.
- `next_pend` clears on FS.
- Several pulses within one frame give a single advance.
- When `iNext` and the auto rollover coincide in the same FS, the mode advances by exactly one.

**Other rules**
- `oFrame_cnt` increments on every FS.
- The mode never changes mid-frame; `oMode` equals the registered `mode`.
- Coordinates outside the active area (X ≥ `H_ACTIVE` or Y ≥ `V_ACTIVE`) produce RGB=0.

## Timing
- Reset (`iRST_N`=0 at a rising edge) sets: RGB=0, `oMode`=BARS, `oFrame_cnt`=0, `frame_in_mode`=0, `next_pend`=0, and the V_SYNC history register=1, so that no false FS occurs on release.
- Reset mid-frame: output returns to BARS on the first cycle after release, without waiting for FS.
- Pixel latency: the RGB for coordinate (X,Y) is registered and appears 1 cycle after the coordinate. `color_bar` accounts for this 1-cycle host latency.
- FS latency: `iVGA_V_SYNC` is registered once. On the falling edge seen at cycle n, FS is asserted at n+1 and the new `oMode` is visible at n+2. The new mode therefore takes effect well inside vertical blanking.
- `FRAMES_PER_MODE`=1 in auto: the mode advances on every FS.

## Structure
- Shared package `tpg_pkg` holds:
  - mode encodings (BARS..SOLID, `MODE_NUM`=5);
  - the 8 bar colour constants as 30-bit {R,G,B};
  - the 10-bit full-scale constant.
- Sub-module `tpg_pixel_gen` is purely combinational and contains no state: inputs are mode, X, Y and solid colour; output is 30-bit RGB.
- `tpg_sequencer` owns the FS detector, the mode FSM, the counters, `next_pend` and the output register.

## Test plan
- Reset held, then released with `iAuto`=1 and defaults → RGB=0 during reset; X=0..79 → 3FF/3FF/3FF, X=80 → 3FF/3FF/000 (yellow), X=560 → 000/000/000; `oMode`=0.
- Auto with `FRAMES_PER_MODE`=2 → `oMode` sequence 0,0,1,1,2,2,3,3,4,4,0 across successive FS; `oFrame_cnt` = 10 after 10 frames.
- Three `iNext` pulses mid-frame, `iAuto`=0, `iMode`=0 → `oMode`=1 after the next FS, not 3; on the following FS `oMode` returns to `iMode`=0.
- `iNext` in the same FS as the auto rollover (mode 2) → `oMode`=3, then `frame_in_mode` restarts.
- Manual `iMode`=6 → BARS; `iMode`=2 at (X=32,Y=0) → white, (X=32,Y=32) → black; `iMode`=4 with `iSolid_RGB`={10'h155,10'h2AA,10'h0F0} → exact colour; X=640 → 0.
- Assert `iRST_N`=0 for 1 cycle in mode 3 mid-frame → next cycle `oMode`=0, `oFrame_cnt`=0, no spurious FS.
